attn_seq_ctrl: RTL

ATTN_SEQ_CTRL -- requirements
Module: attn_seq_ctrl

---
 rtl/attn_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/attn_seq_ctrl.sv
// Token sequencer for the attention pipeline: assembles Q/K/V frames and tracks in-flight valids.
// Optional macro ATTN_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module attn_seq_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int TOKEN_DIM   = 4,
    parameter int TOKEN_NUM   = 8,
    parameter int PIPE_STAGES = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  tok_valid,
    output logic                                  tok_ready,
    input  logic                                  tok_last,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       tok_q,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       tok_k,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       tok_v,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q_buf,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K_buf,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_buf,
    output logic                                  pipe_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  err_frame
`ifdef ATTN_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]                           frame_cnt
`endif
);

    localparam int ROW_W = DATA_WIDTH * TOKEN_DIM;
    localparam int BUF_W = ROW_W * TOKEN_NUM;
    localparam int CNT_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOKEN_NUM - 1);

    typedef enum logic {LOAD = 1'b0, ISSUE = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PIPE_STAGES-1:0] v_q, v_d;
    logic                   err_q, err_d;
    logic [BUF_W-1:0]       q_buf_q, k_buf_q, v_buf_q;
    logic                   accept;
    logic                   issue_fire;
    logic                   wr_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        v_d        = v_q;
        err_d      = err_q;
        tok_ready  = (state_q == LOAD);
        pipe_en    = !v_q[PIPE_STAGES-1] || out_ready;
        accept     = tok_valid && tok_ready;
        issue_fire = (state_q == ISSUE) && pipe_en;
        wr_en      = accept && !flush;

        if (pipe_en) begin
            v_d[0] = issue_fire;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                v_d[i] = v_q[i-1];
            end
        end

        // flush wins over any accept or issue on the same cycle
        if (flush) begin
            state_d = LOAD;
            cnt_d   = '0;
            v_d     = '0;
        end else if (state_q == LOAD) begin
            if (accept) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                    if (!tok_last) begin
                        err_d = 1'b1;
                    end
                end else if (tok_last) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (issue_fire) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            v_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    // Each row is written only by the accept that lands on its counter slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_buf_q <= '0;
            k_buf_q <= '0;
            v_buf_q <= '0;
        end else begin
            for (int i = 0; i < TOKEN_NUM; i++) begin
                if (wr_en && (cnt_q == CNT_W'(i))) begin
                    q_buf_q[i*ROW_W +: ROW_W] <= tok_q;
                    k_buf_q[i*ROW_W +: ROW_W] <= tok_k;
                    v_buf_q[i*ROW_W +: ROW_W] <= tok_v;
                end
            end
        end
    end

    assign Q_buf     = q_buf_q;
    assign K_buf     = k_buf_q;
    assign V_buf     = v_buf_q;
    assign out_valid = v_q[PIPE_STAGES-1];
    assign err_frame = err_q;

`ifdef ATTN_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
